uart_comm: RTL and testbench

- Byte-level UART link layer that sits directly downstream of the multichannel packetiser.
- Accepts 8-bit packet bytes via push strobe into a TX FIFO and serialises them onto Tx as 8N1 frames.
- Deserialises Rx frames into an RX FIFO that the packetiser pops.
- Provides the packetiser's sendable/receivable flow-control signals.

---
 rtl/uart_comm_if.sv | 21 ++
 rtl/uart_comm.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_uart_comm.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_comm_if.sv
// Packetiser-facing byte bus of uart_comm: TX push side and RX pop side.
interface uart_comm_if;
  logic       send_flag;
  logic [7:0] data;
  logic       sendable;
  logic       recv_flag;
  logic [7:0] recv_data;
  logic       receivable;

  // Packetiser side
  modport master (
    output send_flag, data, recv_flag,
    input  sendable, recv_data, receivable
  );

  // UART side
  modport slave (
    input  send_flag, data, recv_flag,
    output sendable, recv_data, receivable
  );
endinterface

// File: rtl/uart_comm.sv
// uart_comm: byte-level UART link layer with TX/RX FIFOs and 8N1 framing.
// Optional macro UART_PARITY_EN adds an even parity bit and a sticky parity_err output.
module uart_comm #(
  parameter int unsigned BAUD_RATE      = 115200,
  parameter int unsigned CLOCK_RATE     = 100000000,
  parameter int unsigned FIFO_DEPTH_BIT = 4
) (
  input  logic       CLK,
  input  logic       RST,
  uart_comm_if.slave bus,
  output logic       Tx,
  input  logic       Rx,
  output logic       frame_err
`ifdef UART_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int unsigned BIT_TICKS  = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned HALF_TICKS = BIT_TICKS / 2;
  localparam int unsigned CNT_W      = $clog2(BIT_TICKS);
  localparam int unsigned DEPTH      = 1 << FIFO_DEPTH_BIT;
  localparam int unsigned OCC_W      = FIFO_DEPTH_BIT + 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(BIT_TICKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]                r_tx_mem [DEPTH];
  logic [FIFO_DEPTH_BIT-1:0] r_tx_wr, r_tx_rd;
  logic [OCC_W-1:0]          r_tx_count;
  logic                      w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic [7:0]                w_tx_head;

  tx_state_t        r_tx_state;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [2:0]       r_tx_bit;
  logic [7:0]       r_tx_shift;
  logic             r_tx;
`ifdef UART_PARITY_EN
  logic             r_tx_par;
`endif

  assign w_tx_full     = (r_tx_count == OCC_FULL);
  assign w_tx_empty    = (r_tx_count == '0);
  assign w_tx_push     = bus.send_flag && !w_tx_full;
  assign w_tx_head     = r_tx_mem[r_tx_rd];
  // Pop in IDLE, or at the end of a stop bit so frames run back to back
  assign w_tx_pop      = !w_tx_empty &&
                         ((r_tx_state == TX_IDLE) ||
                          ((r_tx_state == TX_STOP) && (r_tx_cnt == TICK_LAST)));
  assign bus.sendable  = !w_tx_full;
  assign Tx            = r_tx;

  // TX FIFO storage write
  always_ff @(posedge CLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= bus.data;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + 1'b1;
        2'b01:   r_tx_count <= r_tx_count - 1'b1;
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  // TX framing FSM: each state lasts one bit time, Tx is registered
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_pop) begin
            r_tx_shift <= w_tx_head;
`ifdef UART_PARITY_EN
            r_tx_par   <= ^w_tx_head;
`endif
            r_tx_cnt   <= '0;
            r_tx       <= 1'b0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_cnt == TICK_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx       <= r_tx_shift[0];
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == TICK_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              r_tx       <= r_tx_par;
              r_tx_state <= TX_PARITY;
`else
              r_tx       <= 1'b1;
              r_tx_state <= TX_STOP;
`endif
            end else begin
              r_tx_bit   <= r_tx_bit + 1'b1;
              r_tx_shift <= r_tx_shift >> 1;
              r_tx       <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (r_tx_cnt == TICK_LAST) begin
            r_tx_cnt   <= '0;
            r_tx       <= 1'b1;
            r_tx_state <= TX_STOP;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
`endif
        TX_STOP: begin
          if (r_tx_cnt == TICK_LAST) begin
            r_tx_cnt <= '0;
            if (w_tx_pop) begin
              r_tx_shift <= w_tx_head;
`ifdef UART_PARITY_EN
              r_tx_par   <= ^w_tx_head;
`endif
              r_tx       <= 1'b0;
              r_tx_state <= TX_START;
            end else begin
              r_tx_state <= TX_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: begin
          r_tx       <= 1'b1;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic [7:0]                r_rx_mem [DEPTH];
  logic [FIFO_DEPTH_BIT-1:0] r_rx_wr, r_rx_rd;
  logic [OCC_W-1:0]          r_rx_count;
  logic                      w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
  logic                      w_rx_stop_sample, w_rx_byte_ok;

  logic             r_rx_meta, r_rx_s;
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             r_rx_wait;
  logic             r_frame_err;
`ifdef UART_PARITY_EN
  logic             r_rx_par_bad;
  logic             r_parity_err;
  assign parity_err = r_parity_err;
`endif

  assign w_rx_full        = (r_rx_count == OCC_FULL);
  assign w_rx_empty       = (r_rx_count == '0);
  assign w_rx_pop         = bus.recv_flag && !w_rx_empty;
  assign w_rx_stop_sample = (r_rx_state == RX_STOP) && !r_rx_wait && (r_rx_cnt == TICK_LAST);
`ifdef UART_PARITY_EN
  assign w_rx_byte_ok     = w_rx_stop_sample && r_rx_s && !r_rx_par_bad;
`else
  assign w_rx_byte_ok     = w_rx_stop_sample && r_rx_s;
`endif
  // A byte arriving into a full FIFO is silently dropped
  assign w_rx_push        = w_rx_byte_ok && !w_rx_full;
  assign bus.receivable   = !w_rx_empty;
  assign bus.recv_data    = r_rx_mem[r_rx_rd];
  assign frame_err        = r_frame_err;

  // Two-flop synchroniser for the asynchronous Rx line
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= Rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // RX FIFO storage, pointers and occupancy; storage cleared so the head reads 0 after reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(DEPTH); i++) r_rx_mem[i] <= '0;
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_rx_push) begin
        r_rx_mem[r_rx_wr] <= r_rx_shift;
        r_rx_wr           <= r_rx_wr + 1'b1;
      end
      if (w_rx_pop) r_rx_rd <= r_rx_rd + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + 1'b1;
        2'b01:   r_rx_count <= r_rx_count - 1'b1;
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // RX deframing FSM: mid-bit sampling, glitch rejection, stop/parity checks
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_wait    <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par_bad <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_s) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt <= '0;
            if (r_rx_s) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_bit   <= '0;
              r_rx_state <= RX_DATA;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == TICK_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              r_rx_state <= RX_PARITY;
`else
              r_rx_state <= RX_STOP;
`endif
            end else begin
              r_rx_bit <= r_rx_bit + 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (r_rx_cnt == TICK_LAST) begin
            r_rx_cnt     <= '0;
            r_rx_par_bad <= r_rx_s ^ (^r_rx_shift);
            r_rx_state   <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (r_rx_wait) begin
            // Line held low past the stop bit: wait for it to return idle
            if (r_rx_s) begin
              r_rx_wait  <= 1'b0;
              r_rx_state <= RX_IDLE;
            end
          end else if (r_rx_cnt == TICK_LAST) begin
            r_rx_cnt <= '0;
            if (r_rx_s) begin
`ifdef UART_PARITY_EN
              if (r_rx_par_bad) r_parity_err <= 1'b1;
`endif
              r_rx_state <= RX_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_rx_wait   <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_comm.sv
// Bench for uart_comm: directed TX waveform, loopback RX scoreboard, glitch/framing/reset cases.
module tb_uart_comm;

  localparam int unsigned BT = 16;
`ifdef UART_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned FRAME = BT * NBITS;

  logic CLK;
  logic RST;
  logic Tx;
  logic Rx;
  logic frame_err;
  logic rx_drv;
  logic loop;
`ifdef UART_PARITY_EN
  logic parity_err;
`endif

  int checks;
  int errors;
  logic [7:0] exp_q[$];

  uart_comm_if bus ();

  assign Rx = loop ? Tx : rx_drv;

  uart_comm #(
    .BAUD_RATE     (1),
    .CLOCK_RATE    (16),
    .FIFO_DEPTH_BIT(4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .Tx        (Tx),
    .Rx        (Rx),
    .frame_err (frame_err)
`ifdef UART_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Line bits of a frame, index 0 = start bit
  function automatic logic [NBITS-1:0] frame_of(input logic [7:0] b);
`ifdef UART_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  task automatic push(input logic [7:0] b);
    @(negedge CLK);
    bus.send_flag = 1'b1;
    bus.data      = b;
    @(posedge CLK);
    #1 bus.send_flag = 1'b0;
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
    logic [NBITS-1:0] fb;
    fb = frame_of(b);
    fb[NBITS-1] = stop_bit;
    for (int i = 0; i < int'(NBITS); i++) begin
      @(negedge CLK) rx_drv = fb[i];
      repeat (BT - 1) @(negedge CLK);
    end
    @(negedge CLK) rx_drv = 1'b1;
  endtask

  // Scoreboard monitor: pops RX FIFO whenever it is non-empty and compares with the queue
  initial begin
    bus.recv_flag = 1'b0;
    forever begin
      @(negedge CLK);
      if (bus.recv_flag) begin
        bus.recv_flag = 1'b0;
      end else if (!RST && bus.receivable) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got byte %02h, expected none (t=%0t)", bus.recv_data, $time);
        end else begin
          check("rx_byte", 32'(bus.recv_data), 32'(exp_q.pop_front()));
        end
        bus.recv_flag = 1'b1;
      end
    end
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NBITS-1:0] fb;
    int c;
    int lows;
    checks        = 0;
    errors        = 0;
    RST           = 1'b1;
    bus.send_flag = 1'b0;
    bus.data      = 8'h00;
    loop          = 1'b0;
    rx_drv        = 1'b1;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_tx", 32'(Tx), 32'd1);
    check("rst_sendable", 32'(bus.sendable), 32'd1);
    check("rst_receivable", 32'(bus.receivable), 32'd0);
    check("rst_recv_data", 32'(bus.recv_data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    @(negedge CLK) RST = 1'b0;
    repeat (3) @(posedge CLK);

    // Single frame 0xA5: 2-cycle latency, then each line bit held BT cycles
    push(8'hA5);
    check("tx_latency_hold", 32'(Tx), 32'd1);
    @(posedge CLK);
    #1;
    fb = frame_of(8'hA5);
    for (int k = 0; k < int'(FRAME); k++) begin
      check("tx_a5_bit", 32'(Tx), 32'(fb[k / int'(BT)]));
      if ((k % int'(BT)) == 0) check("tx_a5_sendable", 32'(bus.sendable), 32'd1);
      @(posedge CLK);
      #1;
    end
    check("tx_a5_idle", 32'(Tx), 32'd1);
    repeat (10) @(posedge CLK);

    // 17-byte burst into idle TX, looped back into RX
    loop = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 17; i++) begin
      bus.send_flag = 1'b1;
      bus.data      = 8'(i);
      exp_q.push_back(8'(i));
      @(posedge CLK);
      #1;
      if (i == 0)  check("burst_no_fall_yet", 32'(Tx), 32'd1);
      if (i == 1)  check("burst_first_fall", 32'(Tx), 32'd0);
      if (i == 15) check("burst_sendable_15", 32'(bus.sendable), 32'd1);
    end
    check("burst_full", 32'(bus.sendable), 32'd0);
    bus.data = 8'h11;
    @(posedge CLK);
    #1 bus.send_flag = 1'b0;
    check("burst_drop_full", 32'(bus.sendable), 32'd0);
    c = 16;
    for (int k = 1; k <= 17; k++) begin
      while (c < k * int'(FRAME) - 1) begin
        @(posedge CLK);
        #1;
        c++;
      end
      check("burst_stop_tail", 32'(Tx), 32'd1);
      @(posedge CLK);
      #1;
      c++;
      check("burst_frame_edge", 32'(Tx), 32'(k == 17));
    end
    check("burst_sendable_after", 32'(bus.sendable), 32'd1);
    repeat (100) @(posedge CLK);
    #1;
    check("burst_rx_drained", 32'(exp_q.size()), 32'd0);

    // Loopback of 0x3C, 0xFF, 0x00
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    push(8'h3C);
    push(8'hFF);
    push(8'h00);
    repeat (3 * FRAME + 100) @(posedge CLK);
    #1;
    check("loop3_drained", 32'(exp_q.size()), 32'd0);
    check("loop3_receivable", 32'(bus.receivable), 32'd0);
    loop = 1'b0;
    repeat (20) @(posedge CLK);

    // Short low glitch on Rx: rejected
    @(negedge CLK) rx_drv = 1'b0;
    repeat (5) @(negedge CLK);
    rx_drv = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    check("glitch_frame_err", 32'(frame_err), 32'd0);
    check("glitch_receivable", 32'(bus.receivable), 32'd0);

    // Bad stop bit, then a good frame
    drive_rx(8'h55, 1'b0);
    repeat (30) @(posedge CLK);
    #1;
    check("badstop_frame_err", 32'(frame_err), 32'd1);
    check("badstop_receivable", 32'(bus.receivable), 32'd0);
    exp_q.push_back(8'h12);
    drive_rx(8'h12, 1'b1);
    repeat (40) @(posedge CLK);
    #1;
    check("good_after_bad_drained", 32'(exp_q.size()), 32'd0);
    check("frame_err_sticky", 32'(frame_err), 32'd1);

    // Reset mid DATA bit with three bytes queued
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      bus.send_flag = 1'b1;
      bus.data      = 8'hC0 + 8'(i);
      @(posedge CLK);
      #1;
    end
    bus.send_flag = 1'b0;
    repeat (40) @(posedge CLK);
    #1;
    check("pre_rst_in_frame", 32'(Tx), 32'(frame_of(8'hC0) >> 2) & 32'd1);
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK);
    #1;
    check("midrst_tx", 32'(Tx), 32'd1);
    check("midrst_sendable", 32'(bus.sendable), 32'd1);
    check("midrst_receivable", 32'(bus.receivable), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    @(negedge CLK) RST = 1'b0;
    lows = 0;
    repeat (3 * FRAME) begin
      @(posedge CLK);
      #1;
      if (Tx == 1'b0) lows++;
    end
    check("midrst_tx_quiet_cycles", 32'(lows), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
